// File: rtl/segasys1_prgarb_if.sv
// segasys1_prgarb_if: requester, ROM and status signals of the program-ROM arbiter
interface segasys1_prgarb_if #(
  parameter int AW = 15,
  parameter int DW = 8
);
  logic          dl_en;
  logic          a_req;
  logic          a_m1;
  logic [AW-1:0] a_ad;
  logic          a_ack;
  logic [DW-1:0] a_dt;
  logic          b_req;
  logic [AW-1:0] b_ad;
  logic          b_ack;
  logic [DW-1:0] b_dt;
  logic          rom_rd;
  logic [AW:0]   rom_ad;
  logic [DW-1:0] rom_dt;
  logic          busy;
  modport master (
    output dl_en, a_req, a_m1, a_ad, b_req, b_ad, rom_dt,
    input  a_ack, a_dt, b_ack, b_dt, rom_rd, rom_ad, busy
  );
  modport slave (
    input  dl_en, a_req, a_m1, a_ad, b_req, b_ad, rom_dt,
    output a_ack, a_dt, b_ack, b_dt, rom_rd, rom_ad, busy
  );
endinterface

// File: rtl/segasys1_prgarb.sv
// segasys1_prgarb: shares one program-ROM read port between CPU fetch (A) and a secondary reader (B)
module segasys1_prgarb #(
  parameter int AW      = 15,
  parameter int DW      = 8,
  parameter int ROM_LAT = 1,
  parameter int STARVE  = 4
) (
  input logic clk,
  input logic rst_n,
  segasys1_prgarb_if.slave bus
);
  localparam int SW = $clog2(STARVE + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HOLD} state_t;
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          own_q, own_d;
  logic [AW:0]   ad_q, ad_d;
  logic [DW-1:0] adt_q, adt_d, bdt_q, bdt_d;
  logic          grant_a;
  assign grant_a = bus.a_req && (starve_q < SW'(STARVE) || !bus.b_req);
  // next-state, address latch, data capture and B-starvation tracking
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    own_d    = own_q;
    ad_d     = ad_q;
    adt_d    = adt_q;
    bdt_d    = bdt_q;
    case (state_q)
      IDLE: begin
        if (bus.dl_en) state_d = HOLD;
        else if (grant_a) begin
          own_d   = 1'b0;
          ad_d    = {bus.a_m1, bus.a_ad};
          state_d = ISSUE;
        end else if (bus.b_req) begin
          own_d   = 1'b1;
          ad_d    = {1'b0, bus.b_ad};
          state_d = ISSUE;
        end
        if (!bus.b_req) starve_d = '0;
        else if (!bus.dl_en) starve_d = grant_a ? (starve_q == SW'(STARVE) ? starve_q : starve_q + 1'b1) : '0;
      end
      ISSUE: begin
        cnt_d   = 3'(ROM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          adt_d   = own_q ? adt_q : bus.rom_dt;
          bdt_d   = own_q ? bus.rom_dt : bdt_q;
          state_d = DONE;
        end else cnt_d = cnt_q - 3'd1;
      end
      DONE: state_d = IDLE;
      HOLD: state_d = bus.dl_en ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state register with asynchronous abort of any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      own_q    <= 1'b0;
      ad_q     <= '0;
      adt_q    <= '0;
      bdt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      own_q    <= own_d;
      ad_q     <= ad_d;
      adt_q    <= adt_d;
      bdt_q    <= bdt_d;
    end
  end
  assign bus.rom_rd = state_q == ISSUE;
  assign bus.rom_ad = ad_q;
  assign bus.a_ack  = state_q == DONE && !own_q;
  assign bus.b_ack  = state_q == DONE && own_q;
  assign bus.a_dt   = adt_q;
  assign bus.b_dt   = bdt_q;
  assign bus.busy   = state_q != IDLE;
endmodule

// File: tb/tb_segasys1_prgarb.sv
// tb_segasys1_prgarb: scoreboard bench for the program-ROM arbiter at ROM latencies 1 and 3
module tb_segasys1_prgarb;
  typedef struct {logic port; logic [7:0] dt; int cyc;} ack_t;
  typedef struct {logic [15:0] ad; int cyc;} rd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  ack_t aq1[$], aq3[$];
  rd_t  rq1[$], rq3[$];
  logic       rd_sr1;
  logic [2:0] rd_sr3;
  segasys1_prgarb_if #(.AW(15), .DW(8)) if1 ();
  segasys1_prgarb_if #(.AW(15), .DW(8)) if3 ();
  segasys1_prgarb #(.ROM_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  segasys1_prgarb #(.ROM_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  always #5 clk = ~clk;
  // cycle index: value seen at a negedge names the cycle that began at the previous posedge
  always @(posedge clk) cyc <= cyc + 1;
  // ROM models: data only valid ROM_LAT cycles after the strobe, junk otherwise
  always @(posedge clk) begin
    rd_sr1 <= if1.rom_rd;
    rd_sr3 <= {rd_sr3[1:0], if3.rom_rd};
  end
  assign if1.rom_dt = rd_sr1 ? (if1.rom_ad[7:0] ^ 8'h5A) : 8'hEE;
  assign if3.rom_dt = rd_sr3[2] ? (if3.rom_ad[7:0] ^ 8'h5A) : 8'hEE;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic flag(input string name);
    n_run++;
    n_fail++;
    $display("FAIL %s unexpected event at cycle %0d", name, cyc);
  endtask
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  // monitor: every ack and ROM strobe must match the next scoreboard entry
  always @(negedge clk) begin
    ack_t a;
    rd_t r;
    if (if1.a_ack || if1.b_ack) begin
      chk("ack1_excl", {31'd0, if1.a_ack && if1.b_ack}, 32'd0);
      if (aq1.size() == 0) flag("ack1_unexp");
      else begin
        a = aq1.pop_front();
        chk("ack1_port", {31'd0, if1.b_ack}, {31'd0, a.port});
        chk("ack1_dt", {24'd0, if1.b_ack ? if1.b_dt : if1.a_dt}, {24'd0, a.dt});
        chk("ack1_cyc", cyc, a.cyc);
      end
    end
    if (if1.rom_rd) begin
      if (rq1.size() == 0) flag("rd1_unexp");
      else begin
        r = rq1.pop_front();
        chk("rd1_ad", {16'd0, if1.rom_ad}, {16'd0, r.ad});
        chk("rd1_cyc", cyc, r.cyc);
      end
    end
    if (if3.a_ack || if3.b_ack) begin
      if (aq3.size() == 0) flag("ack3_unexp");
      else begin
        a = aq3.pop_front();
        chk("ack3_port", {31'd0, if3.b_ack}, {31'd0, a.port});
        chk("ack3_dt", {24'd0, if3.b_ack ? if3.b_dt : if3.a_dt}, {24'd0, a.dt});
        chk("ack3_cyc", cyc, a.cyc);
      end
    end
    if (if3.rom_rd) begin
      if (rq3.size() == 0) flag("rd3_unexp");
      else begin
        r = rq3.pop_front();
        chk("rd3_ad", {16'd0, if3.rom_ad}, {16'd0, r.ad});
        chk("rd3_cyc", cyc, r.cyc);
      end
    end
  end
  initial begin
    int c;
    int nb;
    logic p;
    {if1.dl_en, if1.a_req, if1.a_m1, if1.a_ad, if1.b_req, if1.b_ad} = '0;
    {if3.dl_en, if3.a_req, if3.a_m1, if3.a_ad, if3.b_req, if3.b_ad} = '0;
    #1;
    chk("rst_outs", {if1.a_ack, if1.b_ack, if1.rom_rd, if1.busy, if1.a_dt, if1.b_dt, if1.rom_ad}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // single A fetch, ROM_LAT=1
    @(negedge clk);
    c = cyc;
    if1.a_req = 1'b1; if1.a_m1 = 1'b1; if1.a_ad = 15'h1234;
    rq1.push_back('{16'h9234, c + 1});
    aq1.push_back('{1'b0, 8'h6E, c + 3});
    wait_to(c + 3);
    if1.a_req = 1'b0;
    // single B read of the top address, ROM_LAT=3, busy for 5 cycles
    @(negedge clk);
    c = cyc;
    if3.b_req = 1'b1; if3.b_ad = 15'h7FFF;
    rq3.push_back('{16'h7FFF, c + 1});
    aq3.push_back('{1'b1, 8'hA5, c + 5});
    nb = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      nb += int'(if3.busy);
      if (i == 5) if3.b_req = 1'b0;
    end
    chk("busy3_len", nb, 5);
    // download raised during WAIT: ack still issued, then held off until dl_en falls
    @(negedge clk);
    c = cyc;
    if1.a_req = 1'b1; if1.a_m1 = 1'b0; if1.a_ad = 15'h0456;
    rq1.push_back('{16'h0456, c + 1});
    aq1.push_back('{1'b0, 8'h0C, c + 3});
    wait_to(c + 2);
    if1.dl_en = 1'b1;
    wait_to(c + 6);
    chk("hold_busy", {31'd0, if1.busy}, 32'd1);
    wait_to(c + 10);
    if1.dl_en = 1'b0;
    rq1.push_back('{16'h0456, c + 12});
    aq1.push_back('{1'b0, 8'h0C, c + 14});
    wait_to(c + 11);
    chk("post_dl_idle", {31'd0, if1.busy}, 32'd0);
    wait_to(c + 14);
    if1.a_req = 1'b0;
    // reset in the middle of a read aborts it without an ack
    @(negedge clk);
    c = cyc;
    if1.a_req = 1'b1; if1.a_ad = 15'h0777;
    rq1.push_back('{16'h0777, c + 1});
    wait_to(c + 2);
    rst_n = 1'b0;
    if1.a_req = 1'b0;
    #1;
    chk("rst_mid_outs", {if1.a_ack, if1.b_ack, if1.rom_rd, if1.busy, if1.a_dt, if1.b_dt, if1.rom_ad}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // chained A reads with the address changed during the ack cycle
    @(negedge clk);
    c = cyc;
    if1.a_req = 1'b1; if1.a_ad = 15'h0100;
    rq1.push_back('{16'h0100, c + 1});
    aq1.push_back('{1'b0, 8'h5A, c + 3});
    rq1.push_back('{16'h0101, c + 5});
    aq1.push_back('{1'b0, 8'h5B, c + 7});
    wait_to(c + 3);
    if1.a_ad = 15'h0101;
    wait_to(c + 7);
    if1.a_req = 1'b0;
    // both ports held: four A grants, then B is forced
    @(negedge clk);
    c = cyc;
    if1.a_req = 1'b1; if1.a_m1 = 1'b1; if1.a_ad = 15'h0011;
    if1.b_req = 1'b1; if1.b_ad = 15'h2233;
    for (int k = 0; k < 10; k++) begin
      p = (k == 4 || k == 9);
      rq1.push_back('{p ? 16'h2233 : 16'h8011, c + 4 * k + 1});
      aq1.push_back('{p, p ? 8'h69 : 8'h4B, c + 4 * k + 3});
    end
    wait_to(c + 39);
    if1.a_req = 1'b0;
    if1.b_req = 1'b0;
    wait_to(c + 50);
    chk("aq1_drained", aq1.size(), 0);
    chk("rq1_drained", rq1.size(), 0);
    chk("aq3_drained", aq3.size(), 0);
    chk("rq3_drained", rq3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
